controlador_temporizador: RTL and testbench

Sequencing controller for a synchronous down counter, with the counter datapath embedded. It loads a start value, counts down once per clock and supports pause/resume and abort. It flags terminal count and can optionally auto-reload for periodic operation. It sits between a simple command source (buttons or a host FSM) and the downstream logic that consumes q and done.

---
 rtl/controlador_temporizador_pkg.sv | 12 +
 rtl/controlador_defs.vh | 10 +
 rtl/controlador_temporizador_contador_carga.sv | 37 +++
 rtl/controlador_temporizador.sv | 102 ++++++++++
 tb/tb_controlador_temporizador.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/controlador_temporizador_pkg.sv
// rtl/controlador_temporizador_pkg.sv - state type for the timer sequencing controller
package controlador_temporizador_pkg;

    // Encodings match the `define constants in controlador_defs.vh
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } estado_t;

endpackage

// File: rtl/controlador_defs.vh
// rtl/controlador_defs.vh - shared state encodings for timer controllers and benches
`ifndef CONTROLADOR_DEFS_VH
`define CONTROLADOR_DEFS_VH

`define CT_IDLE  2'd0
`define CT_RUN   2'd1
`define CT_PAUSE 2'd2
`define CT_DONE  2'd3

`endif

// File: rtl/controlador_temporizador_contador_carga.sv
// rtl/controlador_temporizador_contador_carga.sv - loadable down counter saturating at zero
module contador_carga #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ld,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Load beats decrement; decrement never goes below zero
    always_comb begin
        q_d = q_q;
        if (ld) begin
            q_d = d;
        end else if (en && (q_q != '0)) begin
            q_d = q_q - WIDTH'(1);
        end
    end

    // Count register with synchronous clear
    always_ff @(posedge clk) begin
        if (clr) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/controlador_temporizador.sv
// rtl/controlador_temporizador.sv - start/pause/stop/reload sequencer around a down counter
module controlador_temporizador
    import controlador_temporizador_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    estado_t state_q;
    estado_t state_d;
    logic    ld;
    logic    en;
    logic    load_nonzero;
    logic    last_count;

    assign load_nonzero = (load_val != '0);
    // Current q of one (or less) means this decrement reaches terminal count
    assign last_count   = (q <= WIDTH'(1));

    // Next-state and counter control; priority is stop > start > pause
    always_comb begin
        state_d = state_q;
        ld      = 1'b0;
        en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!stop && start) begin
                    ld      = 1'b1;
                    state_d = load_nonzero ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (pause) begin
                    state_d = ST_PAUSE;
                end else begin
                    en = 1'b1;
                    if (last_count) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (!pause) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (auto_reload) begin
                    if (load_nonzero) begin
                        ld      = 1'b1;
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register with synchronous clear
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    contador_carga #(
        .WIDTH (WIDTH)
    ) u_contador (
        .clk (clk),
        .clr (clr),
        .ld  (ld),
        .en  (en),
        .d   (load_val),
        .q   (q)
    );

    assign busy  = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign done  = (state_q == ST_DONE);
    assign state = state_q;

endmodule

// File: tb/tb_controlador_temporizador.sv
// tb/tb_controlador_temporizador.sv - directed self-checking bench for controlador_temporizador
module tb_controlador_temporizador;

    localparam int W = 6;
    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_DONE = 2'd3;

    logic         clk = 1'b0;
    logic         clr, start, stop, pause, auto_reload;
    logic [W-1:0] load_val;
    logic [W-1:0] q;
    logic         busy, done;
    logic [1:0]   state;

    int n_cmp = 0;
    int n_err = 0;

    controlador_temporizador #(.WIDTH(W)) dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .auto_reload (auto_reload),
        .load_val    (load_val),
        .q           (q),
        .busy        (busy),
        .done        (done),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        clr = 0; start = 0; stop = 0; pause = 0; auto_reload = 0;
    endtask

    task automatic test_reset;
        clr = 1;
        for (int i = 0; i < 2; i++) begin
            start = 1'($urandom); stop = 1'($urandom); pause = 1'($urandom);
            auto_reload = 1'($urandom); load_val = W'($urandom);
            tick();
        end
        n_cmp++; if (state !== S_IDLE) begin n_err++; $display("FAIL reset_state got %0d want %0d", state, S_IDLE); end
        n_cmp++; if (q !== 6'd0) begin n_err++; $display("FAIL reset_q got %0d want 0", q); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        idle_inputs();
    endtask

    task automatic test_count;
        load_val = 5; start = 1; tick(); start = 0;
        for (int i = 0; i <= 5; i++) begin
            if (i == 2) load_val = 33;
            n_cmp++; if (q !== W'(5 - i)) begin n_err++; $display("FAIL count_q step %0d got %0d want %0d", i, q, 5 - i); end
            n_cmp++; if (state !== ((i < 5) ? S_RUN : S_DONE)) begin n_err++; $display("FAIL count_state step %0d got %0d", i, state); end
            n_cmp++; if (done !== (i == 5)) begin n_err++; $display("FAIL count_done step %0d got %b", i, done); end
            n_cmp++; if (busy !== (i < 5)) begin n_err++; $display("FAIL count_busy step %0d got %b", i, busy); end
            tick();
        end
        n_cmp++; if (state !== S_IDLE || busy !== 1'b0 || done !== 1'b0 || q !== 6'd0) begin
            n_err++; $display("FAIL count_end state %0d busy %b done %b q %0d want 0/0/0/0", state, busy, done, q); end
    endtask

    task automatic test_pause;
        load_val = 10; start = 1; tick(); start = 0;
        tick(); tick(); tick();
        n_cmp++; if (q !== 6'd7) begin n_err++; $display("FAIL pause_pre_q got %0d want 7", q); end
        pause = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++; if (q !== 6'd7 || state !== S_PAUSE || busy !== 1'b1) begin
                n_err++; $display("FAIL pause_hold cyc %0d q %0d state %0d busy %b want 7/2/1", k, q, state, busy); end
        end
        pause = 0; tick();
        n_cmp++; if (q !== 6'd7 || state !== S_RUN) begin n_err++; $display("FAIL pause_resume q %0d state %0d want 7/1", q, state); end
        for (int k = 6; k >= 0; k--) begin
            tick();
            n_cmp++; if (q !== W'(k)) begin n_err++; $display("FAIL pause_count got %0d want %0d", q, k); end
        end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL pause_done got %b want 1", done); end
        tick();
    endtask

    task automatic test_auto_reload;
        logic [W-1:0] seq [4];
        seq[0] = 3; seq[1] = 2; seq[2] = 1; seq[3] = 0;
        auto_reload = 1; load_val = 3; start = 1; tick(); start = 0;
        for (int n = 1; n <= 11; n++) begin
            tick();
            n_cmp++; if (q !== seq[n % 4]) begin n_err++; $display("FAIL reload_q n %0d got %0d want %0d", n, q, seq[n % 4]); end
            n_cmp++; if (done !== (n % 4 == 3)) begin n_err++; $display("FAIL reload_done n %0d got %b want %b", n, done, (n % 4 == 3)); end
            if (n == 8) auto_reload = 0;
        end
        tick();
        n_cmp++; if (state !== S_IDLE || q !== 6'd0) begin n_err++; $display("FAIL reload_end state %0d q %0d want 0/0", state, q); end
    endtask

    task automatic test_stop;
        logic seen_done;
        seen_done = 0;
        load_val = 20; start = 1; tick(); start = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (done) seen_done = 1;
        end
        n_cmp++; if (q !== 6'd12) begin n_err++; $display("FAIL stop_pre_q got %0d want 12", q); end
        stop = 1; tick(); stop = 0;
        n_cmp++; if (state !== S_IDLE || q !== 6'd12) begin n_err++; $display("FAIL stop_hold state %0d q %0d want 0/12", state, q); end
        tick(); tick();
        if (done) seen_done = 1;
        n_cmp++; if (seen_done !== 1'b0 || q !== 6'd12) begin n_err++; $display("FAIL stop_no_done seen %b q %0d want 0/12", seen_done, q); end
        start = 1; tick(); start = 0;
        n_cmp++; if (q !== 6'd20 || state !== S_RUN) begin n_err++; $display("FAIL stop_restart q %0d state %0d want 20/1", q, state); end
        stop = 1; tick(); stop = 0;
    endtask

    task automatic test_clr_mid;
        load_val = 15; start = 1; tick(); start = 0;
        for (int k = 0; k < 6; k++) tick();
        n_cmp++; if (q !== 6'd9) begin n_err++; $display("FAIL clr_pre_q got %0d want 9", q); end
        clr = 1; start = 1; load_val = 0; tick(); clr = 0; start = 0;
        n_cmp++; if (state !== S_IDLE || q !== 6'd0) begin n_err++; $display("FAIL clr_mid state %0d q %0d want 0/0", state, q); end
        start = 1; tick(); start = 0;
        n_cmp++; if (state !== S_DONE || done !== 1'b1 || busy !== 1'b0 || q !== 6'd0) begin
            n_err++; $display("FAIL zero_load state %0d done %b busy %b q %0d want 3/1/0/0", state, done, busy, q); end
        tick();
        n_cmp++; if (state !== S_IDLE) begin n_err++; $display("FAIL zero_load_end state %0d want 0", state); end
    endtask

    task automatic test_boundaries;
        load_val = 4; start = 1; stop = 1; tick(); start = 0; stop = 0;
        n_cmp++; if (state !== S_IDLE || q !== 6'd0) begin n_err++; $display("FAIL stop_start state %0d q %0d want 0/0", state, q); end
        load_val = 2; start = 1; tick(); start = 0;
        tick();
        n_cmp++; if (q !== 6'd1) begin n_err++; $display("FAIL edge_q1 got %0d want 1", q); end
        pause = 1; tick();
        n_cmp++; if (state !== S_PAUSE || q !== 6'd1) begin n_err++; $display("FAIL pause_at_one state %0d q %0d want 2/1", state, q); end
        start = 1; tick();
        n_cmp++; if (state !== S_PAUSE || q !== 6'd1) begin n_err++; $display("FAIL start_in_pause state %0d q %0d want 2/1", state, q); end
        start = 0; pause = 0; tick();
        n_cmp++; if (state !== S_RUN || q !== 6'd1) begin n_err++; $display("FAIL resume_one state %0d q %0d want 1/1", state, q); end
        tick();
        n_cmp++; if (state !== S_DONE || q !== 6'd0) begin n_err++; $display("FAIL one_to_done state %0d q %0d want 3/0", state, q); end
        auto_reload = 1; load_val = 0; tick();
        n_cmp++; if (state !== S_DONE || done !== 1'b1 || q !== 6'd0) begin n_err++; $display("FAIL reload_zero state %0d done %b q %0d want 3/1/0", state, done, q); end
        auto_reload = 0; tick();
        n_cmp++; if (state !== S_IDLE) begin n_err++; $display("FAIL reload_zero_exit state %0d want 0", state); end
        load_val = 3; start = 1; tick();
        load_val = 9; tick(); start = 0;
        n_cmp++; if (state !== S_RUN || q !== 6'd2) begin n_err++; $display("FAIL start_in_run state %0d q %0d want 1/2", state, q); end
        stop = 1; tick(); stop = 0;
        n_cmp++; if (state !== S_IDLE || q !== 6'd2) begin n_err++; $display("FAIL stop_run state %0d q %0d want 0/2", state, q); end
    endtask

    initial begin
        idle_inputs();
        load_val = 0;
        #2;
        test_reset();
        test_count();
        test_pause();
        test_auto_reload();
        test_stop();
        test_clr_mid();
        test_boundaries();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
